rob_nport: RTL and testbench



---
 rtl/rob_nport.sv | 158 +++++++++++++++
 tb/tb_rob_nport.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_nport.sv
// Reorder buffer with NUM_CDB writeback ports and in-order single-entry commit.
// Latency: alloc/writeback become visible one cycle after the edge; commit_* is combinational from the head entry.
// Backpressure: alloc_ready drops when full or on a flushing commit; the head is held while commit_ready is low.
module rob_nport #(
    parameter int DEPTH   = 32,
    parameter int NUM_CDB = 2,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic [31:0]              alloc_pc,
    input  logic [4:0]               alloc_rd_addr,
    output logic                     alloc_ready,
    output logic [IDX_W-1:0]         alloc_idx,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*IDX_W-1:0] cdb_idx,
    input  logic [NUM_CDB*32-1:0]    cdb_data,
    input  logic [NUM_CDB-1:0]       cdb_mispredict,
    output logic                     commit_valid,
    input  logic                     commit_ready,
    output logic [IDX_W-1:0]         commit_idx,
    output logic [31:0]              commit_pc,
    output logic [4:0]               commit_rd_addr,
    output logic [31:0]              commit_data,
    output logic                     commit_mispredict,
    output logic                     flush_o,
    output logic [IDX_W:0]           count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam logic [IDX_W:0]   LP_DEPTH   = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   LP_CNT_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] LP_PTR_ONE = IDX_W'(1);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    logic [DEPTH-1:0] r_mp;
    logic [31:0]      r_pc   [DEPTH];
    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;
    logic             r_flush;

    logic             w_full;
    logic             w_empty;
    logic             w_commit_vld;
    logic             w_commit_fire;
    logic             w_flush_fire;
    logic             w_alloc_fire;
    logic [DEPTH-1:0] w_wb_hit;
    logic [DEPTH-1:0] w_wb_mp;
    logic [31:0]      w_wb_data [DEPTH];

    assign w_full        = (r_count == LP_DEPTH);
    assign w_empty       = (r_count == '0);
    assign w_commit_vld  = !w_empty && r_done[r_head];
    assign w_commit_fire = w_commit_vld && commit_ready;
    assign w_flush_fire  = w_commit_fire && r_mp[r_head];
    // Allocation never waits on a same-cycle commit to free a slot.
    assign alloc_ready   = !w_full && !w_flush_fire;
    assign w_alloc_fire  = alloc_valid && alloc_ready;

    assign alloc_idx         = r_tail;
    assign commit_valid      = w_commit_vld;
    assign commit_idx        = r_head;
    assign commit_pc         = r_pc[r_head];
    assign commit_rd_addr    = r_rd[r_head];
    assign commit_data       = r_data[r_head];
    assign commit_mispredict = r_mp[r_head];
    assign flush_o           = r_flush;
    assign count_o           = r_count;
    assign full_o            = w_full;
    assign empty_o           = w_empty;

    // Scan ports from highest to lowest so the lowest-numbered port wins a collision.
    always_comb begin
        w_wb_hit = '0;
        w_wb_mp  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wb_data[i] = '0;
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (cdb_valid[p] && (cdb_idx[p*IDX_W +: IDX_W] == IDX_W'(i))) begin
                    w_wb_hit[i]  = 1'b1;
                    w_wb_mp[i]   = cdb_mispredict[p];
                    w_wb_data[i] = cdb_data[p*32 +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_flush <= 1'b0;
        end else begin
            r_flush <= w_flush_fire;
            if (w_flush_fire) begin
                r_head  <= r_head + LP_PTR_ONE;
                r_tail  <= r_head + LP_PTR_ONE;
                r_count <= '0;
            end else begin
                if (w_commit_fire) begin
                    r_head <= r_head + LP_PTR_ONE;
                end
                if (w_alloc_fire) begin
                    r_tail <= r_tail + LP_PTR_ONE;
                end
                if (w_alloc_fire && !w_commit_fire) begin
                    r_count <= r_count + LP_CNT_ONE;
                end else if (!w_alloc_fire && w_commit_fire) begin
                    r_count <= r_count - LP_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_done  <= '0;
            r_mp    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else if (w_flush_fire) begin
            r_valid <= '0;
            r_done  <= '0;
            r_mp    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_fire && (r_tail == IDX_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_done[i]  <= 1'b0;
                    r_mp[i]    <= 1'b0;
                    r_pc[i]    <= alloc_pc;
                    r_rd[i]    <= alloc_rd_addr;
                end else if (w_wb_hit[i] && r_valid[i]) begin
                    r_done[i]  <= 1'b1;
                    r_mp[i]    <= w_wb_mp[i];
                    r_data[i]  <= w_wb_data[i];
                end
                if (w_commit_fire && (r_head == IDX_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_nport.sv
// Bench for rob_nport (DEPTH=4, NUM_CDB=2): directed scenarios plus random traffic against a queue model.
// Expected commits go to a scoreboard drained by an independent commit monitor.
module tb_rob_nport;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic [4:0]  alloc_rd_addr;
    logic        alloc_ready;
    logic [1:0]  alloc_idx;
    logic [1:0]  cdb_valid;
    logic [3:0]  cdb_idx;
    logic [63:0] cdb_data;
    logic [1:0]  cdb_mispredict;
    logic        commit_valid;
    logic        commit_ready;
    logic [1:0]  commit_idx;
    logic [31:0] commit_pc;
    logic [4:0]  commit_rd_addr;
    logic [31:0] commit_data;
    logic        commit_mispredict;
    logic        flush_o;
    logic [2:0]  count_o;
    logic        full_o;
    logic        empty_o;

    rob_nport #(.DEPTH(DEPTH), .NUM_CDB(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_valid       (alloc_valid),
        .alloc_pc          (alloc_pc),
        .alloc_rd_addr     (alloc_rd_addr),
        .alloc_ready       (alloc_ready),
        .alloc_idx         (alloc_idx),
        .cdb_valid         (cdb_valid),
        .cdb_idx           (cdb_idx),
        .cdb_data          (cdb_data),
        .cdb_mispredict    (cdb_mispredict),
        .commit_valid      (commit_valid),
        .commit_ready      (commit_ready),
        .commit_idx        (commit_idx),
        .commit_pc         (commit_pc),
        .commit_rd_addr    (commit_rd_addr),
        .commit_data       (commit_data),
        .commit_mispredict (commit_mispredict),
        .flush_o           (flush_o),
        .count_o           (count_o),
        .full_o            (full_o),
        .empty_o           (empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        done;
        logic [31:0] data;
        logic        mp;
    } ent_t;

    // Model: occupied entries in allocation order; the front is the head.
    ent_t       mq[$];
    ent_t       sb[$];
    logic [1:0] m_tail;
    logic       m_flush;
    int         n_chk;
    int         n_pass;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    task automatic clear_inputs();
        alloc_valid    = 1'b0;
        alloc_pc       = '0;
        alloc_rd_addr  = '0;
        cdb_valid      = '0;
        cdb_idx        = '0;
        cdb_data       = '0;
        cdb_mispredict = '0;
        commit_ready   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_commit_valid"}, 32'(commit_valid), 32'd0);
        check({tag, "_count"},        32'(count_o),      32'd0);
        check({tag, "_empty"},        32'(empty_o),      32'd1);
        check({tag, "_full"},         32'(full_o),       32'd0);
        check({tag, "_alloc_ready"},  32'(alloc_ready),  32'd1);
        check({tag, "_alloc_idx"},    32'(alloc_idx),    32'd0);
        check({tag, "_flush"},        32'(flush_o),      32'd0);
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic cycle(input logic av, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [1:0] cv, input logic [3:0] ci, input logic [63:0] cd,
                         input logic [1:0] cm, input logic cr);
        logic e_cv, e_fire, e_flush, e_ar, hit;
        ent_t t;
        alloc_valid    = av;
        alloc_pc       = pc;
        alloc_rd_addr  = rd;
        cdb_valid      = cv;
        cdb_idx        = ci;
        cdb_data       = cd;
        cdb_mispredict = cm;
        commit_ready   = cr;
        e_cv    = (mq.size() > 0) && mq[0].done;
        e_fire  = e_cv && cr;
        e_flush = e_fire && mq[0].mp;
        e_ar    = (mq.size() < DEPTH) && !e_flush;
        if (e_fire) sb.push_back(mq[0]);
        @(negedge clk);
        check("alloc_ready",  32'(alloc_ready),  32'(e_ar));
        check("alloc_idx",    32'(alloc_idx),    32'(m_tail));
        check("count",        32'(count_o),      32'(mq.size()));
        check("full",         32'(full_o),       32'(mq.size() == DEPTH));
        check("empty",        32'(empty_o),      32'(mq.size() == 0));
        check("flush",        32'(flush_o),      32'(m_flush));
        check("commit_valid", 32'(commit_valid), 32'(e_cv));
        @(posedge clk);
        m_flush = e_flush;
        if (e_flush) begin
            m_tail = mq[0].idx + 2'd1;
            mq.delete();
        end else begin
            for (int k = 0; k < mq.size(); k++) begin
                t   = mq[k];
                hit = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (!hit && cv[p] && (ci[p*2 +: 2] == t.idx)) begin
                        hit    = 1'b1;
                        t.done = 1'b1;
                        t.data = cd[p*32 +: 32];
                        t.mp   = cm[p];
                    end
                end
                mq[k] = t;
            end
            if (e_fire) void'(mq.pop_front());
            if (av && e_ar) begin
                t = '{idx: m_tail, pc: pc, rd: rd, done: 1'b0, data: 32'd0, mp: 1'b0};
                mq.push_back(t);
                m_tail = m_tail + 2'd1;
            end
        end
        #1;
    endtask

    task automatic idle(input logic cr);
        cycle(1'b0, 32'd0, 5'd0, 2'b00, 4'd0, 64'd0, 2'b00, cr);
    endtask

    // Asserts reset between edges and checks the outputs before the next edge.
    task automatic do_reset();
        clear_inputs();
        check("sb_drained", 32'(sb.size()), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_reset_state("rst");
        mq.delete();
        sb.delete();
        m_tail  = '0;
        m_flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (!rst && commit_valid && commit_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_commit: idx %0d pc %0h with no commit expected", commit_idx, commit_pc);
            end else begin
                e = sb.pop_front();
                check("commit_idx",  32'(commit_idx),        32'(e.idx));
                check("commit_pc",   commit_pc,              e.pc);
                check("commit_rd",   32'(commit_rd_addr),    32'(e.rd));
                check("commit_data", commit_data,            e.data);
                check("commit_mp",   32'(commit_mispredict), 32'(e.mp));
            end
        end
    end

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        m_tail  = '0;
        m_flush = 1'b0;
        rst     = 1'b1;
        clear_inputs();
        #3;
        check_reset_state("init");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill all four entries, then try one more while full.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 32'h100 + 32'(4*k), 5'(k + 1), 2'b00, 4'd0, 64'd0, 2'b00, 1'b0);
        end
        check("dir_full",  32'(full_o),  32'd1);
        check("dir_count", 32'(count_o), 32'd4);
        cycle(1'b1, 32'h200, 5'd9, 2'b00, 4'd0, 64'd0, 2'b00, 1'b0);

        // Out-of-order completion: idx 2 then idx 0, commit only idx 0.
        cycle(1'b0, 32'd0, 5'd0, 2'b01, 4'd2, 64'h0000_00AA, 2'b00, 1'b1);
        cycle(1'b0, 32'd0, 5'd0, 2'b01, 4'd0, 64'h0000_00BB, 2'b00, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Both ports hit idx 1; port 0 (0x11, mispredict) wins, its commit flushes 2 and 3.
        cycle(1'b0, 32'd0, 5'd0, 2'b11, {2'd1, 2'd1}, {32'h22, 32'h11}, 2'b01, 1'b1);
        cycle(1'b1, 32'h300, 5'd3, 2'b00, 4'd0, 64'd0, 2'b00, 1'b1);
        check("dir_flush",     32'(flush_o),   32'd1);
        check("dir_flush_idx", 32'(alloc_idx), 32'd2);
        idle(1'b1);
        idle(1'b1);

        // Streaming alloc/complete/commit across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'h400 + 32'(4*k), 5'(k), (k > 0) ? 2'b01 : 2'b00,
                  {2'd0, m_tail - 2'd1}, {32'd0, 32'(k)}, 2'b00, 1'b1);
            check("stream_count_bound", 32'(count_o <= 3'd4), 32'd1);
        end
        repeat (4) idle(1'b1);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom, 5'($urandom),
                  2'($urandom), 4'($urandom), {$urandom, $urandom},
                  {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
                  ($urandom_range(0, 3) != 0));
        end

        // Mid-stream reset with three entries, one done.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h500 + 32'(4*k), 5'(k), 2'b00, 4'd0, 64'd0, 2'b00, 1'b0);
        end
        cycle(1'b0, 32'd0, 5'd0, 2'b01, 4'd0, 64'h77, 2'b00, 1'b0);
        check("pre_rst_commit_valid", 32'(commit_valid), 32'd1);
        do_reset();
        cycle(1'b1, 32'h600, 5'd1, 2'b00, 4'd0, 64'd0, 2'b00, 1'b0);

        for (int k = 0; k < 300; k++) begin
            cycle(($urandom_range(0, 1) != 0), $urandom, 5'($urandom),
                  2'($urandom), 4'($urandom), {$urandom, $urandom},
                  {($urandom_range(0, 7) == 0), 1'b0}, ($urandom_range(0, 3) != 0));
        end
        check("sb_drained_end", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
